// File: rtl/gen_meter_if.sv
// Sample stream, window control and result handshake between the control side and gen_meter.
// The master drives samples and control; the slave returns status and results.
interface gen_meter_if #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned ACC_W = 2 * IN_W + WIN_W
);
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    start;
    logic        [WIN_W-1:0] win_len;
    logic                    busy;
    logic                    rd_valid;
    logic                    rd_ack;
    logic signed [IN_W-1:0]  peak_pos;
    logic signed [IN_W-1:0]  peak_neg;
    logic        [ACC_W-1:0] energy;
    logic        [WIN_W-1:0] zc_count;

    modport master (
        output in_data, in_valid, start, win_len, rd_ack,
        input  busy, rd_valid, peak_pos, peak_neg, energy, zc_count
    );

    modport slave (
        input  in_data, in_valid, start, win_len, rd_ack,
        output busy, rd_valid, peak_pos, peak_neg, energy, zc_count
    );
endinterface

// File: rtl/gen_meter.sv
// Windowed signal meter: positive/negative peak, sum of squares and zero-crossing count
// over a programmed number of samples, with results held behind a valid/ack handshake.
module gen_meter #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned ACC_W = 2 * IN_W + WIN_W
) (
    input logic        adc_clk,
    input logic        reset,
    gen_meter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic signed [IN_W-1:0] MinVal = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [IN_W-1:0] MaxVal = {1'b0, {(IN_W-1){1'b1}}};

    state_e                    state_q, state_d;
    logic        [WIN_W:0]     rem_q, rem_d;
    logic                      flush_q, flush_d;
    logic signed [IN_W-1:0]    s_q, s_d;
    logic                      s_vld_q, s_vld_d;
    logic        [2*IN_W-1:0]  sq_q, sq_d;
    logic                      sq_vld_q, sq_vld_d;
    logic        [ACC_W-1:0]   acc_q, acc_d;
    logic signed [IN_W-1:0]    max_q, max_d;
    logic signed [IN_W-1:0]    min_q, min_d;
    logic        [WIN_W-1:0]   zc_q, zc_d;
    logic                      first_q, first_d;
    logic                      prev_sign_q, prev_sign_d;
    logic                      busy_q, busy_d;
    logic                      rd_valid_q, rd_valid_d;
    logic signed [IN_W-1:0]    pp_q, pp_d;
    logic signed [IN_W-1:0]    pn_q, pn_d;
    logic        [ACC_W-1:0]   en_q, en_d;
    logic        [WIN_W-1:0]   zcc_q, zcc_d;

    logic                      accept;
    logic                      begin_win;
    logic signed [2*IN_W-1:0]  prod;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        flush_d     = flush_q;
        acc_d       = acc_q;
        max_d       = max_q;
        min_d       = min_q;
        zc_d        = zc_q;
        first_d     = first_q;
        prev_sign_d = prev_sign_q;
        busy_d      = busy_q;
        rd_valid_d  = rd_valid_q;
        pp_d        = pp_q;
        pn_d        = pn_q;
        en_d        = en_q;
        zcc_d       = zcc_q;
        begin_win   = 1'b0;

        // Pipeline: register sample, then square and track peaks/sign, then accumulate.
        accept   = (state_q == StRun) && bus.in_valid;
        s_d      = accept ? bus.in_data : s_q;
        s_vld_d  = accept;
        prod     = s_q * s_q;
        sq_d     = s_vld_q ? unsigned'(prod) : sq_q;
        sq_vld_d = s_vld_q;

        if (s_vld_q) begin
            if (s_q > max_q) max_d = s_q;
            if (s_q < min_q) min_d = s_q;
            if (!first_q && (s_q[IN_W-1] != prev_sign_q)) zc_d = zc_q + WIN_W'(1);
            prev_sign_d = s_q[IN_W-1];
            first_d     = 1'b0;
        end
        if (sq_vld_q) acc_d = acc_q + ACC_W'(sq_q);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin_win = 1'b1;
            end
            StRun: begin
                if (accept) begin
                    rem_d = rem_q - (WIN_W+1)'(1);
                    if (rem_q == (WIN_W+1)'(1)) begin
                        state_d = StFlush;
                        flush_d = 1'b0;
                    end
                end
            end
            StFlush: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d    = StDone;
                    busy_d     = 1'b0;
                    rd_valid_d = 1'b1;
                    pp_d       = max_q;
                    pn_d       = min_q;
                    en_d       = acc_q + (sq_vld_q ? ACC_W'(sq_q) : '0);
                    zcc_d      = zc_q;
                end
            end
            StDone: begin
                if (bus.start) begin
                    begin_win  = 1'b1;
                    rd_valid_d = 1'b0;
                end else if (bus.rd_ack) begin
                    state_d    = StIdle;
                    rd_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (begin_win) begin
            state_d = StRun;
            busy_d  = 1'b1;
            rem_d   = (bus.win_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, bus.win_len};
            max_d   = MinVal;
            min_d   = MaxVal;
            acc_d   = '0;
            zc_d    = '0;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            flush_q     <= 1'b0;
            s_q         <= '0;
            s_vld_q     <= 1'b0;
            sq_q        <= '0;
            sq_vld_q    <= 1'b0;
            acc_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            zc_q        <= '0;
            first_q     <= 1'b0;
            prev_sign_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            pp_q        <= '0;
            pn_q        <= '0;
            en_q        <= '0;
            zcc_q       <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            flush_q     <= flush_d;
            s_q         <= s_d;
            s_vld_q     <= s_vld_d;
            sq_q        <= sq_d;
            sq_vld_q    <= sq_vld_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            min_q       <= min_d;
            zc_q        <= zc_d;
            first_q     <= first_d;
            prev_sign_q <= prev_sign_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            pp_q        <= pp_d;
            pn_q        <= pn_d;
            en_q        <= en_d;
            zcc_q       <= zcc_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.peak_pos = pp_q;
    assign bus.peak_neg = pn_q;
    assign bus.energy   = en_q;
    assign bus.zc_count = zcc_q;
endmodule
